dzcpu_useq: RTL and testbench

- Micro-sequencer that consumes the microcode ROM. It is the reader side of the opcode-LUT / uop-ROM pair.
- Accepts fetched opcode bytes and turns each one into a micro-PC through the main or CB flow-index LUT. It then walks the uop ROM one uop per cycle and issues each uop to the dzcpu datapath.
- Honours per-uop flow control (inc, eof, conditional eof, CB jump) and datapath stall.
- Sits between the fetch/memory port and the datapath inside dzcpu.

---
 rtl/dzcpu_useq_pkg.sv | 23 ++
 rtl/dzcpu_useq.sv | 113 +++++++++++
 tb/tb_dzcpu_useq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dzcpu_useq_pkg.sv
// Shared microcode encodings for the dzcpu micro-sequencer.
// Values match the uop ROM's flow and command defines.
package dzcpu_useq_pkg;

  localparam logic [2:0] FlowOp      = 3'd0;
  localparam logic [2:0] FlowInc     = 3'd1;
  localparam logic [2:0] FlowEof     = 3'd2;
  localparam logic [2:0] FlowIncEof  = 3'd3;
  localparam logic [2:0] FlowIncEofZ = 3'd4;

  localparam int unsigned UopFlowHi = 11;
  localparam int unsigned UopFlowLo = 9;
  localparam int unsigned UopCmdHi  = 8;
  localparam int unsigned UopCmdLo  = 4;
  localparam int unsigned UopOpndHi = 3;
  localparam int unsigned UopOpndLo = 0;

  localparam logic [4:0] CmdJcb = 5'h1F;

  localparam logic [0:0] StDispatch = 1'b0;
  localparam logic [0:0] StExec     = 1'b1;

endpackage

// File: rtl/dzcpu_useq.sv
// Micro-sequencer: maps fetched opcodes to a micro-PC via the external LUTs,
// then walks the uop ROM one uop per cycle honouring flow control and stalls.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int unsigned UPC_W  = 8,
  parameter int unsigned UOP_W  = 12,
  parameter int unsigned ICNT_W = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [7:0]        iMop,
  input  logic              iMopValid,
  input  logic [UPC_W-1:0]  iFlowIdx,
  input  logic [UPC_W-1:0]  iCbFlowIdx,
  output logic [UPC_W-1:0]  oUopAddr,
  input  logic [UOP_W-1:0]  iUop,
  input  logic              iFlagZ,
  input  logic              iUopStall,
  output logic [UOP_W-1:0]  oUop,
  output logic              oUopValid,
  output logic              oIncPc,
  output logic              oFetchReq,
  output logic [ICNT_W-1:0] oInstrCount,
  output logic              oUcodeErr
);

  logic [0:0]        state_q, state_d;
  logic [UPC_W-1:0]  upc_q, upc_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;
  logic              err_q, err_d;

  logic [2:0] flow;
  logic [4:0] cmd;
  logic       exec, is_jcb, retire, upc_max;
  logic       inc_pc, do_eof, do_next;
  logic       unused_mop;

  assign flow    = iUop[UopFlowHi:UopFlowLo];
  assign cmd     = iUop[UopCmdHi:UopCmdLo];
  assign exec    = (state_q == StExec);
  assign is_jcb  = (cmd == CmdJcb);
  // jcb needs the CB byte on the bus; without it the uop waits like a stall.
  assign retire  = exec && !iUopStall && (!is_jcb || iMopValid);
  assign upc_max = &upc_q;
  // The opcode byte itself is only consumed by the external LUTs.
  assign unused_mop = ^iMop;

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    icnt_d  = icnt_q;
    err_d   = err_q;
    inc_pc  = 1'b0;
    do_eof  = 1'b0;
    do_next = 1'b0;
    if (!exec) begin
      if (iMopValid) begin
        upc_d   = iFlowIdx;
        state_d = StExec;
      end
    end else if (retire) begin
      case (flow)
        FlowOp:      do_next = 1'b1;
        FlowInc:     begin inc_pc = 1'b1; do_next = 1'b1; end
        FlowEof:     do_eof = 1'b1;
        FlowIncEof:  begin inc_pc = 1'b1; do_eof = 1'b1; end
        FlowIncEofZ: begin
          inc_pc = 1'b1;
          if (iFlagZ) do_eof = 1'b1;
          else        do_next = 1'b1;
        end
        default:     begin do_eof = 1'b1; err_d = 1'b1; end
      endcase
      if (is_jcb) begin
        upc_d = iCbFlowIdx;
      end else if (do_eof) begin
        state_d = StDispatch;
        icnt_d  = icnt_q + ICNT_W'(1);
      end else if (do_next) begin
        if (upc_max) begin
          err_d   = 1'b1;
          state_d = StDispatch;
        end else begin
          upc_d = upc_q + UPC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= StDispatch;
      upc_q   <= '0;
      icnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      icnt_q  <= icnt_d;
      err_q   <= err_d;
    end
  end

  assign oUopAddr    = upc_q;
  assign oUopValid   = exec;
  assign oUop        = exec ? iUop : '0;
  assign oIncPc      = inc_pc;
  assign oFetchReq   = !exec;
  assign oInstrCount = icnt_q;
  assign oUcodeErr   = err_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Scoreboard bench for dzcpu_useq: expected uop streams are queued per
// instruction and compared cycle by cycle while the flow executes.
module tb_dzcpu_useq;
  import dzcpu_useq_pkg::*;

  localparam int unsigned UpcW  = 8;
  localparam int unsigned UopW  = 12;
  // Narrow counter keeps the wrap scenario short.
  localparam int unsigned IcntW = 10;

  typedef struct packed {
    logic [7:0] addr;
    logic       inc;
  } exp_t;

  logic             iClock = 1'b0;
  logic             iReset;
  logic [7:0]       iMop;
  logic             iMopValid;
  logic [UpcW-1:0]  iFlowIdx;
  logic [UpcW-1:0]  iCbFlowIdx;
  logic [UpcW-1:0]  oUopAddr;
  logic [UopW-1:0]  iUop;
  logic             iFlagZ;
  logic             iUopStall;
  logic [UopW-1:0]  oUop;
  logic             oUopValid;
  logic             oIncPc;
  logic             oFetchReq;
  logic [IcntW-1:0] oInstrCount;
  logic             oUcodeErr;

  logic [UopW-1:0]  rom [256];
  exp_t             expq [$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [IcntW-1:0] exp_count;

  always #5 iClock = ~iClock;
  assign iUop = rom[oUopAddr];

  dzcpu_useq #(.UPC_W(UpcW), .UOP_W(UopW), .ICNT_W(IcntW)) u_dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iMop       (iMop),
    .iMopValid  (iMopValid),
    .iFlowIdx   (iFlowIdx),
    .iCbFlowIdx (iCbFlowIdx),
    .oUopAddr   (oUopAddr),
    .iUop       (iUop),
    .iFlagZ     (iFlagZ),
    .iUopStall  (iUopStall),
    .oUop       (oUop),
    .oUopValid  (oUopValid),
    .oIncPc     (oIncPc),
    .oFetchReq  (oFetchReq),
    .oInstrCount(oInstrCount),
    .oUcodeErr  (oUcodeErr)
  );

  function automatic logic [11:0] mk(logic [2:0] f, logic [4:0] c, logic [3:0] o);
    return {f, c, o};
  endfunction

  task automatic init_rom();
    for (int i = 0; i < 256; i++) rom[i] = mk(FlowEof, 5'h02, i[3:0]);
    rom[0]   = mk(3'd7, 5'h05, 4'h0);
    rom[1]   = mk(FlowInc, 5'h03, 4'h1);
    rom[2]   = mk(FlowInc, 5'h04, 4'h2);
    rom[3]   = mk(FlowOp, 5'h05, 4'h3);
    rom[4]   = mk(FlowIncEof, 5'h06, 4'h4);
    rom[12]  = mk(FlowEof, 5'h07, 4'hC);
    rom[13]  = mk(FlowOp, 5'h08, 4'hD);
    rom[14]  = mk(FlowOp, 5'h09, 4'hE);
    rom[15]  = mk(FlowOp, CmdJcb, 4'hF);
    rom[16]  = mk(FlowEof, 5'h0A, 4'h0);
    rom[17]  = mk(FlowInc, 5'h0B, 4'h1);
    rom[18]  = mk(FlowInc, 5'h0C, 4'h2);
    rom[19]  = mk(FlowIncEofZ, 5'h0D, 4'h3);
    rom[20]  = mk(FlowOp, 5'h0E, 4'h4);
    rom[21]  = mk(FlowOp, 5'h0F, 4'h5);
    rom[22]  = mk(FlowIncEof, 5'h10, 4'h6);
    rom[255] = mk(FlowOp, 5'h11, 4'hA);
  endtask

  task automatic push(input logic [7:0] a, input logic inc);
    exp_t e;
    e.addr = a;
    e.inc  = inc;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge iClock);
    iReset = 1'b1; iMopValid = 1'b0; iUopStall = 1'b0; iFlagZ = 1'b0;
    @(negedge iClock);
    iReset = 1'b0;
    exp_count = '0;
  endtask

  task automatic check_status(input string name, input logic err);
    vectors++;
    if (oInstrCount !== exp_count || oUcodeErr !== err) begin
      miscompares++;
      $display("FAIL %s status: got count=%0d err=%b, want count=%0d err=%b",
               name, oInstrCount, oUcodeErr, exp_count, err);
    end
  endtask

  // Dispatches one instruction and checks every issued uop against expq.
  task automatic run_flow(input string name, input logic [7:0] idx, input logic z,
                          input logic [7:0] stall_addr, input int stall_n,
                          input int jcb_hold, input int exp_n);
    int   st = stall_n;
    int   jh = jcb_hold;
    int   n = 0;
    bit   done = 0;
    exp_t e;
    logic [UopW-1:0] w;
    @(negedge iClock);
    iMopValid = 1'b1; iFlowIdx = idx; iUopStall = 1'b0; iFlagZ = z; iMop = 8'h00;
    #1;
    vectors++;
    if (oFetchReq !== 1'b1 || oUopValid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s dispatch: got fetch=%b valid=%b, want fetch=1 valid=0",
               name, oFetchReq, oUopValid);
    end
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge iClock);
      iMopValid = 1'b0; iUopStall = 1'b0;
      if (oFetchReq) begin
        done = 1;
      end else begin
        n++;
        w = rom[oUopAddr];
        if (oUopAddr == stall_addr && st > 0) begin iUopStall = 1'b1; st--; end
        if (w[8:4] == CmdJcb) begin
          if (jh > 0) jh--;
          else begin iMopValid = 1'b1; iMop = 8'h7C; end
        end
        #1;
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra uop: got addr=%0d, want none", name, oUopAddr);
        end else begin
          e = expq.pop_front();
          if (oUopValid !== 1'b1 || oUopAddr !== e.addr || oIncPc !== e.inc ||
              oUop !== rom[e.addr]) begin
            miscompares++;
            $display("FAIL %s uop: got v=%b a=%0d inc=%b u=%h, want v=1 a=%0d inc=%b u=%h",
                     name, oUopValid, oUopAddr, oIncPc, oUop, e.addr, e.inc, rom[e.addr]);
          end
        end
      end
    end
    vectors++;
    if (!done || n != exp_n || expq.size() != 0) begin
      miscompares++;
      $display("FAIL %s length: got %0d uops (done=%0d, %0d unmatched), want %0d",
               name, n, done, expq.size(), exp_n);
    end
    expq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (oUopAddr !== 8'd0 || oUopValid !== 1'b0 || oUop !== 12'h000 || oIncPc !== 1'b0 ||
        oFetchReq !== 1'b1 || oInstrCount !== '0 || oUcodeErr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got a=%0d v=%b u=%h inc=%b f=%b cnt=%0d err=%b, want 0 0 0 0 1 0 0",
               oUopAddr, oUopValid, oUop, oIncPc, oFetchReq, oInstrCount, oUcodeErr);
    end
  endtask

  task automatic test_basic();
    push(1, 1); push(2, 1); push(3, 0); push(4, 1);
    run_flow("basic", 8'd1, 1'b0, 8'hFF, 0, 0, 4);
    exp_count++;
    check_status("basic", 1'b0);
  endtask

  task automatic test_jrnz();
    push(17, 1); push(18, 1); push(19, 1);
    run_flow("jrnz_z1", 8'd17, 1'b1, 8'hFF, 0, 0, 3);
    exp_count++;
    check_status("jrnz_z1", 1'b0);
    push(17, 1); push(18, 1); push(19, 1); push(20, 0); push(21, 0); push(22, 1);
    run_flow("jrnz_z0", 8'd17, 1'b0, 8'hFF, 0, 0, 6);
    exp_count++;
    check_status("jrnz_z0", 1'b0);
  endtask

  task automatic test_cb();
    iCbFlowIdx = 8'd16;
    push(13, 0); push(14, 0); push(15, 0); push(15, 0); push(16, 0);
    run_flow("cb", 8'd13, 1'b0, 8'hFF, 0, 1, 5);
    exp_count++;
    check_status("cb", 1'b0);
  endtask

  task automatic test_stall();
    push(1, 1); push(2, 0); push(2, 0); push(2, 0); push(2, 1); push(3, 0); push(4, 1);
    run_flow("stall", 8'd1, 1'b0, 8'd2, 3, 0, 7);
    exp_count++;
    check_status("stall", 1'b0);
  endtask

  task automatic test_bad_flow();
    push(0, 0);
    run_flow("bad_flow", 8'd0, 1'b0, 8'hFF, 0, 0, 1);
    exp_count++;
    check_status("bad_flow", 1'b1);
  endtask

  task automatic test_reset_midflow();
    bit hit = 0;
    @(negedge iClock);
    iMopValid = 1'b1; iFlowIdx = 8'd17; iFlagZ = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge iClock);
      iMopValid = 1'b0;
      if (oUopValid && oUopAddr == 8'd21) hit = 1;
    end
    iReset = 1'b1;
    @(negedge iClock);
    iReset = 1'b0;
    exp_count = '0;
    #1;
    vectors++;
    if (!hit || oUopAddr !== 8'd0 || oFetchReq !== 1'b1 || oUopValid !== 1'b0 ||
        oUop !== 12'h000 || oUcodeErr !== 1'b0 || oInstrCount !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got hit=%0d a=%0d f=%b v=%b u=%h err=%b cnt=%0d, want 1 0 1 0 0 0 0",
               hit, oUopAddr, oFetchReq, oUopValid, oUop, oUcodeErr, oInstrCount);
    end
  endtask

  task automatic test_upc_wrap();
    push(255, 0);
    run_flow("upc_wrap", 8'd255, 1'b0, 8'h00, 0, 0, 1);
    check_status("upc_wrap", 1'b1);
  endtask

  task automatic test_count_wrap();
    do_reset();
    @(negedge iClock);
    iMopValid = 1'b1; iFlowIdx = 8'd12;
    repeat (2 * ((1 << IcntW) - 1)) @(negedge iClock);
    vectors++;
    if (oInstrCount !== {IcntW{1'b1}}) begin
      miscompares++;
      $display("FAIL count_full: got %0d, want %0d", oInstrCount, (1 << IcntW) - 1);
    end
    repeat (2) @(negedge iClock);
    iMopValid = 1'b0;
    vectors++;
    if (oInstrCount !== '0 || oUcodeErr !== 1'b0) begin
      miscompares++;
      $display("FAIL count_wrap: got count=%0d err=%b, want count=0 err=0",
               oInstrCount, oUcodeErr);
    end
  endtask

  initial begin
    iReset = 1'b0; iMop = 8'h00; iMopValid = 1'b0; iFlowIdx = '0; iCbFlowIdx = '0;
    iFlagZ = 1'b0; iUopStall = 1'b0; exp_count = '0;
    init_rom();
    test_reset();
    test_basic();
    test_jrnz();
    test_cb();
    test_stall();
    test_bad_flow();
    test_reset_midflow();
    test_upc_wrap();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
